alu_sequencer: RTL

- Multi-cycle execute stage directly upstream of the 4×16-bit single-read-port register file.
- Accepts one 16-bit instruction at a time over a valid/ready handshake.
- Reads operands one at a time through the file's single read port, computes the ALU result, and issues the write-back on the file's write port.
- Maintains zero/carry flags and pulses `done` once per completed write-back.

---
 rtl/isa_pkg.sv | 37 +++
 rtl/alu16.sv | 33 +++
 rtl/alu_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit execute stage:
// opcodes, instruction field positions and FSM states.
package isa_pkg;

  localparam int DATA_WIDTH = 16;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 10;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_MOV = 4'd5,
    OP_LDI = 4'd6,
    OP_SHL = 4'd7,
    OP_NOP = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ_A = 2'd1,
    ST_READ_B = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  // Opcodes 8..15 all decode as NOP.
  function automatic logic is_nop(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU with a 17-bit internal path
// so carry/borrow falls out of the top bit.
module alu16
  import isa_pkg::*;
(
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [7:0]            imm8,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry
);

  logic [DATA_WIDTH:0] wide;

  always_comb begin
    wide = '0;
    case (opcode)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_MOV:  wide = {1'b0, a};
      OP_LDI:  wide = {9'h000, imm8};
      OP_SHL:  wide = {a, 1'b0};
      default: wide = '0;
    endcase
    result = wide[DATA_WIDTH-1:0];
    carry  = wide[DATA_WIDTH];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute stage: reads operands through a
// single RF read port, runs the ALU, writes back.
module alu_sequencer #(
  parameter int DATA_WIDTH = isa_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [1:0]            rf_read_index,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic [1:0]            rf_write_index,
  output logic                  rf_write_enable,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  done
);
  import isa_pkg::*;

  state_e                state_q, state_d;
  logic [15:0]           instr_q, instr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;

  logic [3:0]            op_q, op_in;
  logic [1:0]            rd, ra, rb;
  logic [7:0]            imm8;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  in_write;

  assign op_q  = instr_q[OPC_LSB +: 4];
  assign rd    = instr_q[RD_LSB +: 2];
  assign ra    = instr_q[RA_LSB +: 2];
  assign rb    = instr_q[RB_LSB +: 2];
  assign imm8  = instr_q[IMM_LSB +: 8];
  assign op_in = instr[OPC_LSB +: 4];

  alu16 u_alu (
    .opcode (op_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .imm8   (imm8),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          if (is_nop(op_in))
            state_d = ST_IDLE;
          else if (op_in == OP_LDI)
            state_d = ST_WRITE;
          else
            state_d = ST_READ_A;
        end
      end
      ST_READ_A: begin
        op_a_d = rf_read_data;
        if (op_q == OP_MOV || op_q == OP_SHL)
          state_d = ST_WRITE;
        else
          state_d = ST_READ_B;
      end
      ST_READ_B: begin
        op_b_d  = rf_read_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        zero_d = (alu_result == '0);
        if (op_q == OP_ADD || op_q == OP_SUB ||
            op_q == OP_SHL)
          carry_d = alu_carry;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Write-back is gated so a reset cycle never commits.
  assign in_write = (state_q == ST_WRITE) && !reset;

  assign instr_ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    rf_read_index = 2'd0;
    if (state_q == ST_READ_A)
      rf_read_index = ra;
    else if (state_q == ST_READ_B)
      rf_read_index = rb;
  end

  assign rf_write_enable = in_write;
  assign done            = in_write;
  assign rf_write_index  = in_write ? rd : 2'd0;
  assign rf_write_data   = in_write ? alu_result : '0;
  assign flag_zero       = zero_q;
  assign flag_carry      = carry_q;

endmodule
